ccff_chain_loader: RTL

- Configuration-chain driver, the writer end of the ccff_head→ccff_tail protocol used by the fabric's switch/connection block memories.
- Accepts configuration words from the bitstream host over a valid/ready stream and serialises them onto ccff_head.
- Provides a shift enable for the fabric programming-clock gate.
- Optional verify pass: re-shifts the same bitstream and compares ccff_tail against it, counting mismatches.

---
 rtl/ccff_chain_loader_pkg.sv | 17 +
 rtl/ccff_chain_loader_if.sv | 11 +
 rtl/ccff_chain_loader_piso.sv | 35 +++
 rtl/ccff_chain_loader.sv | 116 +++++++++++
 4 files changed

// File: rtl/ccff_chain_loader_pkg.sv
// Shared constants for the configuration-chain loader: FSM encodings and
// the words-per-pass helper used when sizing bitstreams.
package ccff_loader_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_FETCH = 2'd1;
    localparam state_t ST_SHIFT = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    // Host words needed to cover one pass of the chain; the last one may be partial.
    function automatic int words_per_pass(input int chain_len, input int data_w);
        return (chain_len + data_w - 1) / data_w;
    endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Host-side bitstream stream: valid/ready handshake carrying one word per beat.
interface ccff_chain_loader_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/ccff_chain_loader_piso.sv
// Parallel-in serial-out word register: holds the fetched host word and
// presents it LSB first, one bit per shift.
module ccff_piso #(
    parameter int DATA_W = 8
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              shift,
    output logic              bit_out,
    output logic              last_bit
);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [DATA_W-1:0] word_q;
    logic [IDX_W-1:0]  bit_idx;

    // Capture a new word and restart at bit 0, or step to the next bit.
    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            word_q  <= '0;
            bit_idx <= '0;
        end else if (load) begin
            word_q  <= load_data;
            bit_idx <= '0;
        end else if (shift) begin
            bit_idx <= bit_idx + 1'b1;
        end
    end

    assign bit_out  = word_q[bit_idx];
    assign last_bit = (bit_idx == IDX_W'(DATA_W - 1));

endmodule

// File: rtl/ccff_chain_loader.sv
// Writer end of the ccff_head -> ccff_tail configuration chain. Serialises
// host words onto the chain head and optionally re-shifts the same stream
// while comparing the chain tail against it.
//
// state | meaning
// IDLE  | waiting for cmd_start; counters and err cleared on acceptance
// FETCH | s_ready high, chain frozen until the host offers a word
// SHIFT | one word bit per cycle onto ccff_head with shift enable high
// DONE  | one-cycle completion pulse, err captured
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter  int CHAIN_LEN = 48,
    parameter  int DATA_W    = 8,
    localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic                prog_clk,
    input  logic                pReset_n,
    input  logic                cmd_start,
    input  logic                cmd_verify,
    ccff_chain_loader_if.slave  host,
    output logic                ccff_head,
    output logic                ccff_shift_en,
    input  logic                ccff_tail,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [CNT_W-1:0]    mismatch_cnt
);
    state_t           state_q;
    logic             verify_q;
    logic             pass_q;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [CNT_W-1:0] mism_q;
    logic             err_q;

    logic in_shift;
    logic piso_bit;
    logic piso_last;
    logic last_chain;
    logic mism_hit;

    assign in_shift   = (state_q == ST_SHIFT);
    assign last_chain = (bit_cnt_q == CNT_W'(CHAIN_LEN - 1));
    // Only the readback pass compares; pass 0 tail data is stale chain content.
    assign mism_hit   = in_shift && pass_q && (ccff_tail != piso_bit);

    ccff_piso #(.DATA_W(DATA_W)) u_piso (
        .prog_clk  (prog_clk),
        .pReset_n  (pReset_n),
        .load      (host.s_ready && host.s_valid),
        .load_data (host.s_data),
        .shift     (in_shift),
        .bit_out   (piso_bit),
        .last_bit  (piso_last)
    );

    // Sequencing FSM with pass tracking, chain bit count and mismatch counter.
    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            state_q   <= ST_IDLE;
            verify_q  <= 1'b0;
            pass_q    <= 1'b0;
            bit_cnt_q <= '0;
            mism_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_start) begin
                        verify_q  <= cmd_verify;
                        pass_q    <= 1'b0;
                        bit_cnt_q <= '0;
                        mism_q    <= '0;
                        err_q     <= 1'b0;
                        state_q   <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (host.s_valid) state_q <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                    if (mism_hit && !(&mism_q)) mism_q <= mism_q + 1'b1;
                    if (last_chain) begin
                        // Bits above the chain end in a partial last word are dropped here.
                        if (verify_q && !pass_q) begin
                            pass_q    <= 1'b1;
                            bit_cnt_q <= '0;
                            state_q   <= ST_FETCH;
                        end else begin
                            state_q <= ST_DONE;
                        end
                    end else if (piso_last) begin
                        state_q <= ST_FETCH;
                    end
                end
                ST_DONE: begin
                    err_q   <= (mism_q != '0);
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign host.s_ready  = (state_q == ST_FETCH);
    assign ccff_shift_en = in_shift;
    assign ccff_head     = in_shift & piso_bit;
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);
    // err must already be visible during the done pulse, then holds via err_q.
    assign err           = err_q | (done && (mism_q != '0));
    assign mismatch_cnt  = mism_q;

endmodule
